// File: rtl/alu_pkg.sv
// Shared encodings for the Y86 execute-stage ALU: op codes, CC bit positions,
// condition selectors and the default datapath width.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   typedef enum logic [3:0] {
      C_ALWAYS = 4'd0,
      C_LE     = 4'd1,
      C_L      = 4'd2,
      C_E      = 4'd3,
      C_NE     = 4'd4,
      C_GE     = 4'd5,
      C_G      = 4'd6
   } cond_e;

endpackage

// File: rtl/alu_64_if.sv
// Operand/result bundle between the execute stage (master) and the ALU (slave).
interface alu_64_if #(
   parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             set_cc;
   logic [3:0]       ifun;
   logic [WIDTH-1:0] result;
   logic [2:0]       flags;
   logic [2:0]       cc;
   logic             cnd;

   modport master (
      output a, b, op, set_cc, ifun,
      input  result, flags, cc, cnd
   );

   modport slave (
      input  a, b, op, set_cc, ifun,
      output result, flags, cc, cnd
   );
endinterface

// File: rtl/alu_64_add64.sv
// Ripple-carry adder built from a single-bit full_adder cell. Exposes the carry
// into the MSB as well as the carry-out so the caller can derive signed overflow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add64 #(
   parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             c_msb,
   output logic             cout
);
   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .sum  (sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   assign c_msb = carry[WIDTH-1];
   assign cout  = carry[WIDTH];
endmodule

// File: rtl/alu_64.sv
// Y86 execute-stage ALU: add/sub/and/xor, combinational {ZF,SF,OF}, gated CC register.
// Optional condition evaluation from the CC register is enabled by ALU_COND_EVAL_EN.
module alu_64
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_64_if.slave  bus
);
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] result_val;
   logic             sub_sel;
   logic             c_msb;
   logic             c_out;
   logic             of_val;
   logic [2:0]       flags_val;
   logic [2:0]       cc_reg;

   // Subtraction reuses the adder as a + ~b + 1.
   assign sub_sel = (bus.op == ALU_SUB);
   assign add_b   = sub_sel ? ~bus.b : bus.b;

   add64 #(.WIDTH(WIDTH)) u_add64 (
      .a     (bus.a),
      .b     (add_b),
      .cin   (sub_sel),
      .sum   (sum),
      .c_msb (c_msb),
      .cout  (c_out)
   );

   // Signed overflow of the adder is the carry into the MSB differing from the
   // carry out of it; it never applies to the bitwise ops.
   always_comb begin
      result_val = sum;
      of_val     = 1'b0;
      case (bus.op)
         ALU_ADD, ALU_SUB: begin
            result_val = sum;
            of_val     = c_msb ^ c_out;
         end
         ALU_AND: result_val = bus.a & bus.b;
         ALU_XOR: result_val = bus.a ^ bus.b;
         default: begin
            result_val = 'x;
            of_val     = 1'bx;
         end
      endcase
   end

   always_comb begin
      flags_val        = 3'b000;
      flags_val[CC_ZF] = (result_val == '0);
      flags_val[CC_SF] = result_val[WIDTH-1];
      flags_val[CC_OF] = of_val;
   end

   assign bus.result = result_val;
   assign bus.flags  = flags_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_reg <= 3'b000;
      end else if (bus.set_cc) begin
         cc_reg <= flags_val;
      end
   end

   assign bus.cc = cc_reg;

`ifdef ALU_COND_EVAL_EN
   logic cnd_val;
   logic lt_val;

   assign lt_val = cc_reg[CC_SF] ^ cc_reg[CC_OF];

   always_comb begin
      cnd_val = 1'b0;
      case (bus.ifun)
         C_ALWAYS: cnd_val = 1'b1;
         C_LE:     cnd_val = lt_val | cc_reg[CC_ZF];
         C_L:      cnd_val = lt_val;
         C_E:      cnd_val = cc_reg[CC_ZF];
         C_NE:     cnd_val = ~cc_reg[CC_ZF];
         C_GE:     cnd_val = ~lt_val;
         C_G:      cnd_val = ~lt_val & ~cc_reg[CC_ZF];
         default:  cnd_val = 1'b0;
      endcase
   end

   assign bus.cnd = cnd_val;
`else
   assign bus.cnd = 1'b0;
`endif

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed spec vectors plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_64;
   import alu_pkg::*;

   localparam int W = 64;

   logic clk     = 1'b0;
   logic rst_n   = 1'b1;
   logic clk_run = 1'b0;
   int   errors  = 0;
   int   checks  = 0;
   logic [2:0] cc_model = 3'b000;

   alu_64_if #(.WIDTH(W)) bus ();

   alu_64 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // Overflow: the exact signed result does not fit in W bits.
   function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
      logic signed [W:0] sa, sb, t;
      logic [W-1:0] r;
      logic ovf;
      r   = ref_result(a, b, op);
      sa  = {a[W-1], a};
      sb  = {b[W-1], b};
      ovf = 1'b0;
      if (op == 2'd0) begin
         t   = sa + sb;
         ovf = (t > $signed({2'b00, {(W-1){1'b1}}})) || (t < $signed({2'b11, {(W-1){1'b0}}}));
      end else if (op == 2'd1) begin
         t   = sa - sb;
         ovf = (t > $signed({2'b00, {(W-1){1'b1}}})) || (t < $signed({2'b11, {(W-1){1'b0}}}));
      end
      return {(r == '0), ($signed(r) < 0), ovf};
   endfunction

   function automatic logic ref_cnd(input logic [2:0] cc, input logic [3:0] ifun);
`ifdef ALU_COND_EVAL_EN
      logic less, equal;
      equal = cc[2];
      less  = cc[1] != cc[0];
      case (ifun)
         4'd0:    return 1'b1;
         4'd1:    return less || equal;
         4'd2:    return less;
         4'd3:    return equal;
         4'd4:    return !equal;
         4'd5:    return !less;
         4'd6:    return !less && !equal;
         default: return 1'b0;
      endcase
`else
      return 1'b0 & cc[0] & ifun[0];
`endif
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic s, input logic [3:0] f);
      bus.a      = a;
      bus.b      = b;
      bus.op     = op;
      bus.set_cc = s;
      bus.ifun   = f;
   endtask

   task automatic test_reset;
      drive(64'd5, 64'd7, ALU_ADD, 1'b0, 4'd0);
      #1 rst_n = 1'b0;
      #1;
      $display("txn reset: cc=%b result=%0d", bus.cc, bus.result);
      checks++;
      if (bus.cc !== 3'b000) begin
         errors++;
         $display("FAIL reset_cc got=%b want=000", bus.cc);
      end
      checks++;
      if (bus.result !== 64'd12) begin
         errors++;
         $display("FAIL reset_result_tracks got=%h want=%h", bus.result, 64'd12);
      end
      #1 rst_n = 1'b1;
      clk_run = 1'b1;
   endtask

   task automatic run_vectors(input string name, input logic [W-1:0] va[], input logic [W-1:0] vb[],
                              input logic [1:0] vo[], input logic [W-1:0] er[], input logic [2:0] ef[]);
      for (int i = 0; i < va.size(); i++) begin
         @(negedge clk);
         drive(va[i], vb[i], vo[i], 1'b0, 4'd0);
         #1;
         $display("txn %s[%0d]: a=%h b=%h op=%0d result=%h flags=%b", name, i,
                  va[i], vb[i], vo[i], bus.result, bus.flags);
         checks++;
         if (bus.result !== er[i]) begin
            errors++;
            $display("FAIL %s_result[%0d] got=%h want=%h", name, i, bus.result, er[i]);
         end
         checks++;
         if (bus.flags !== ef[i]) begin
            errors++;
            $display("FAIL %s_flags[%0d] got=%b want=%b", name, i, bus.flags, ef[i]);
         end
      end
   endtask

   task automatic test_add;
      run_vectors("add", '{64'd5, 64'h7FFF_FFFF_FFFF_FFFF}, '{64'd7, 64'd1}, '{ALU_ADD, ALU_ADD},
                  '{64'd12, 64'h8000_0000_0000_0000}, '{3'b000, 3'b011});
   endtask

   task automatic test_sub;
      run_vectors("sub", '{64'd9, 64'd0, 64'h8000_0000_0000_0000}, '{64'd9, 64'd1, 64'd1},
                  '{ALU_SUB, ALU_SUB, ALU_SUB},
                  '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF},
                  '{3'b100, 3'b010, 3'b001});
   endtask

   task automatic test_logic;
      run_vectors("logic", '{64'hF0F0, 64'hF0F0, 64'hAA}, '{64'hFF00, 64'hFF00, 64'hAA},
                  '{ALU_AND, ALU_XOR, ALU_XOR}, '{64'hF000, 64'h0FF0, 64'd0},
                  '{3'b000, 3'b000, 3'b100});
   endtask

   task automatic test_cc_gating;
      @(negedge clk);
      drive(64'd9, 64'd9, ALU_SUB, 1'b1, 4'd0);
      @(posedge clk);
      #1;
      $display("txn cc_load: cc=%b", bus.cc);
      checks++;
      if (bus.cc !== 3'b100) begin
         errors++;
         $display("FAIL cc_load got=%b want=100", bus.cc);
      end
      @(negedge clk);
      drive(64'd5, 64'd7, ALU_ADD, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         $display("txn cc_hold[%0d]: cc=%b", i, bus.cc);
         checks++;
         if (bus.cc !== 3'b100) begin
            errors++;
            $display("FAIL cc_hold[%0d] got=%b want=100", i, bus.cc);
         end
      end
   endtask

   task automatic cond_sweep(input logic [3:0] fl[], input logic [2:0] cc_now);
      for (int i = 0; i < fl.size(); i++) begin
         logic exp;
         exp = ref_cnd(cc_now, fl[i]);
         @(negedge clk);
         drive(64'd5, 64'd7, ALU_ADD, 1'b0, fl[i]);
         #1;
         $display("txn cond: cc=%b ifun=%0d cnd=%b", bus.cc, fl[i], bus.cnd);
         checks++;
         if (bus.cnd !== exp) begin
            errors++;
            $display("FAIL cond_ifun%0d got=%b want=%b", fl[i], bus.cnd, exp);
         end
      end
   endtask

   task automatic test_cond;
      cond_sweep('{4'd3, 4'd4, 4'd1, 4'd6, 4'd0}, 3'b100);
      @(negedge clk);
      drive(64'd0, 64'd1, ALU_SUB, 1'b1, 4'd0);
      @(posedge clk);
      #1;
      checks++;
      if (bus.cc !== 3'b010) begin
         errors++;
         $display("FAIL cc_load_010 got=%b want=010", bus.cc);
      end
      cond_sweep('{4'd2, 4'd5, 4'd9, 4'd15}, 3'b010);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("txn reset_mid: cc=%b cnd=%b", bus.cc, bus.cnd);
      checks++;
      if (bus.cc !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_cc got=%b want=000", bus.cc);
      end
      #1 rst_n = 1'b1;
      cc_model = 3'b000;
   endtask

   task automatic test_random;
      logic [W-1:0] corners [6];
      corners = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 64'hAA};
      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] ra, rb, er;
         logic [1:0]   ro;
         logic [2:0]   ef;
         logic         rs;
         logic [3:0]   rf;
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) rb = ra;
         ro = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         rf = 4'($urandom_range(0, 15));
         er = ref_result(ra, rb, ro);
         ef = ref_flags(ra, rb, ro);
         @(negedge clk);
         drive(ra, rb, ro, rs, rf);
         #1;
         $display("txn rand[%0d]: a=%h b=%h op=%0d set_cc=%b ifun=%0d result=%h flags=%b",
                  i, ra, rb, ro, rs, rf, bus.result, bus.flags);
         checks++;
         if (bus.result !== er) begin
            errors++;
            $display("FAIL rand_result[%0d] got=%h want=%h", i, bus.result, er);
         end
         checks++;
         if (bus.flags !== ef) begin
            errors++;
            $display("FAIL rand_flags[%0d] got=%b want=%b", i, bus.flags, ef);
         end
         if (rs) cc_model = ef;
         @(posedge clk);
         #1;
         checks++;
         if (bus.cc !== cc_model) begin
            errors++;
            $display("FAIL rand_cc[%0d] got=%b want=%b", i, bus.cc, cc_model);
         end
         checks++;
         if (bus.cnd !== ref_cnd(cc_model, rf)) begin
            errors++;
            $display("FAIL rand_cnd[%0d] got=%b want=%b", i, bus.cnd, ref_cnd(cc_model, rf));
         end
      end
   endtask

   initial begin
      drive(64'd0, 64'd0, ALU_ADD, 1'b0, 4'd0);
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_cc_gating();
      test_cond();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_64.md
Name: alu_64

Overview:
- 64-bit Y86 execute-stage ALU with four operations: add, subtract, AND, XOR.
- Produces a combinational result and combinational flags {ZF,SF,OF}.
- Holds a 3-bit condition-code register that is written only when `set_cc` is asserted.
- Instantiated by the execute stage for OPq, address, and stack-pointer arithmetic.

Parameters:
- `WIDTH`, 64, datapath width in bits. All arithmetic is modulo 2^WIDTH.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `op`, in, 2: operation select. 00 = add, 01 = sub, 10 = and, 11 = xor.
- `set_cc`, in, 1: load the CC register at the next rising edge.
- `ifun`, in, 4: condition selector (used only with the optional feature).
- `result`, out, WIDTH: combinational ALU output.
- `flags`, out, 3: combinational {ZF,SF,OF} of the current `result`.
- `cc`, out, 3: registered {ZF,SF,OF}.
- `cnd`, out, 1: condition evaluation result (optional feature).

Behaviour:
- **Operations** (`result` is purely combinational, zero latency):
  - add: `result = a + b`.
  - sub: `result = a - b`, implemented as a + ~b + 1.
  - and: `result = a & b`.
  - xor: `result = a ^ b`.
  - Carry-out is discarded.
- **ZF**: 1 when `result == 0`.
- **SF**: `result[WIDTH-1]`.
- **OF**:
  - add: a[MSB] == b[MSB] and result[MSB] != a[MSB].
  - sub: a[MSB] != b[MSB] and result[MSB] != a[MSB].
  - and/xor: 0.
- **CC register**:
  - When `rst_n` is low, `cc` is cleared to 3'b000 asynchronously, independent of `clk`.
  - On a rising `clk` edge with `set_cc == 1`: `cc <= flags`.
  - On a rising `clk` edge with `set_cc == 0`: `cc` holds.
  - Exactly one cycle of latency from `flags` to `cc`.
- **Reset release**: synchronous to nothing special. The first edge after deassertion behaves normally.
- **Reset mid-operation**: `result` and `flags` keep tracking the inputs; only `cc` (and `cnd`, which is derived from it) is forced.
- **Unknown inputs**: any X/Z input bit produces X on `result`/`flags`. `cc` must not latch X while `set_cc == 0`.
- **Wrap-around**:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 = 0x8000_0000_0000_0000, OF = 1.
  - 0 - 1 = all-ones, OF = 0.
  - 0x8000_0000_0000_0000 - 1 = 0x7FFF_FFFF_FFFF_FFFF, OF = 1.

Optional Feature:
- Macro: `ALU_COND_EVAL_EN`.
- **Defined**: `cnd` is combinational from the registered `cc` and `ifun`:
  - 0 = 1 (always).
  - 1 = (SF^OF)|ZF (le).
  - 2 = SF^OF (l).
  - 3 = ZF (e).
  - 4 = ~ZF (ne).
  - 5 = ~(SF^OF) (ge).
  - 6 = ~(SF^OF)&~ZF (g).
  - 7–15 = 0.
- **Undefined**: `cnd` is tied to 0 and `ifun` is ignored. The port list is identical in both builds.

Decomposition:
- **Package `alu_pkg`**:
  - Op encodings: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_XOR`.
  - CC bit indices: `CC_ZF` = 2, `CC_SF` = 1, `CC_OF` = 0.
  - Condition `ifun` encodings: `C_ALWAYS` through `C_G`.
  - The `WIDTH` default.
- **Sub-module `add64`**: a ripple-carry adder built from a `full_adder` cell.
  - Takes `a`, `b`, and `cin`.
  - Subtraction feeds ~b with `cin = 1`.
- The top level contains:
  - The op multiplexer.
  - Bitwise units.
  - Flag logic.
  - The CC register.
  - The condition block.

Test Plan:
- **Reset**:
  - Hold `rst_n` = 0 with no clock edges: `cc` = 000 immediately.
  - Pulse `rst_n` low mid-run after cc = 010: `cc` returns to 000 asynchronously.
- **Add**:
  - a = 5, b = 7, op = 00: `result` = 12, `flags` = 000.
  - a = 0x7FFF_FFFF_FFFF_FFFF, b = 1: `result` = 0x8000_0000_0000_0000, `flags` = 011.
- **Sub**:
  - a = 9, b = 9, op = 01: `result` = 0, `flags` = 100.
  - a = 0, b = 1: `result` = 0xFFFF_FFFF_FFFF_FFFF, `flags` = 010.
  - a = 0x8000_0000_0000_0000, b = 1: `flags` = 001.
- **And/Xor**:
  - a = 0xF0F0, b = 0xFF00, op = 10: `result` = 0xF000.
  - Same operands, op = 11: `result` = 0x0FF0.
  - a = b = 0xAA, op = 11: `result` = 0, `flags` = 100, OF = 0.
- **CC gating**:
  - Sub 9 - 9 with `set_cc` = 1: after the edge, `cc` = 100.
  - Then add 5 + 7 with `set_cc` = 0 for 3 edges: `cc` stays 100.
- **ALU_COND_EVAL_EN**:
  - With cc = 100: `ifun` = 3 → `cnd` = 1; `ifun` = 4 → 0; `ifun` = 1 → 1; `ifun` = 6 → 0.
  - With cc = 010: `ifun` = 2 → 1; `ifun` = 5 → 0; `ifun` = 9 → 0.
  - Build without the macro: `cnd` = 0 for all cases.
